// File: rtl/alu_4bit_pkg.sv
// alu_4bit_pkg: opcodes and status flag bundle shared by the ALU core and its register stage
package alu_4bit_pkg;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_INC = 3'b110,
    OP_DEC = 3'b111
  } op_e;
  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } flags_t;
endpackage

// File: rtl/alu_4bit_core.sv
// alu_4bit_core: combinational result and flag computation for one ALU operation
module alu_4bit_core
  import alu_4bit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] res,
  output flags_t           flags
);
  logic [WIDTH-1:0] rhs;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             is_add;
  logic             is_sub;
  // INC/DEC reuse the add/sub paths with a constant one as right operand
  always_comb begin
    is_add         = sel == OP_ADD || sel == OP_INC;
    is_sub         = sel == OP_SUB || sel == OP_DEC;
    rhs            = (sel == OP_INC || sel == OP_DEC) ? WIDTH'(1) : b;
    sum            = {1'b0, a} + {1'b0, rhs};
    dif            = {1'b0, a} - {1'b0, rhs};
    res            = is_add        ? sum[WIDTH-1:0] :
                     is_sub        ? dif[WIDTH-1:0] :
                     sel == OP_AND ? a & b :
                     sel == OP_OR  ? a | b :
                     sel == OP_XOR ? a ^ b : ~a;
    flags.carry    = is_add ? sum[WIDTH] : is_sub ? dif[WIDTH] : 1'b0;
    flags.overflow = is_add ? (a[WIDTH-1] == rhs[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]) :
                     is_sub ? (a[WIDTH-1] != rhs[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]) : 1'b0;
    flags.zero     = res == '0;
    flags.negative = res[WIDTH-1];
  end
endmodule

// File: rtl/alu_4bit.sv
// alu_4bit: registered ALU with one-cycle latency, valid tracking and hold on idle cycles
module alu_4bit
  import alu_4bit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             out_valid
);
  logic [WIDTH-1:0] core_res;
  flags_t           core_flags;
  logic [WIDTH-1:0] result_d, result_q;
  flags_t           flags_d, flags_q;
  logic             valid_d, valid_q;
  alu_4bit_core #(.WIDTH(WIDTH)) u_core (
    .a    (A),
    .b    (B),
    .sel  (sel),
    .res  (core_res),
    .flags(core_flags)
  );
  // capture a new result only on valid input, otherwise keep the last one
  always_comb begin
    result_d = in_valid ? core_res : result_q;
    flags_d  = in_valid ? core_flags : flags_q;
    valid_d  = in_valid;
  end
  // output registers; reset clears everything including zero and drops any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
    end
  end
  assign result    = result_q;
  assign carry     = flags_q.carry;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_alu_4bit.sv
// tb_alu_4bit: directed vectors with a queued scoreboard checked by an independent monitor
module tb_alu_4bit;
  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] s;
    logic       ev;
    logic [3:0] er;
    logic [3:0] ef;
  } vec_t;
  typedef struct {
    logic       ev;
    logic [3:0] er;
    logic [3:0] ef;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic [2:0] sel = '0;
  logic [3:0] result;
  logic       carry, overflow, zero, negative, out_valid;
  vec_t       tv[$];
  exp_t       sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  bit         done = 1'b0;
  alu_4bit #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .sel      (sel),
    .result   (result),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative),
    .out_valid(out_valid)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic r, logic v, logic [3:0] a, logic [3:0] b, logic [2:0] s,
                              logic ev, logic [3:0] er, logic [3:0] ef);
    vec_t t;
    t.r = r; t.v = v; t.a = a; t.b = b; t.s = s; t.ev = ev; t.er = er; t.ef = ef;
    return t;
  endfunction
  // monitor: after each edge pop the expected output and compare against the DUT
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_vec++;
      if ({out_valid, result, carry, overflow, zero, negative} !== {e.ev, e.er, e.ef}) begin
        n_err++;
        $display("FAIL vec%0d: got v=%b r=%b cvzn=%b%b%b%b, want v=%b r=%b cvzn=%b",
                 n_vec, out_valid, result, carry, overflow, zero, negative, e.ev, e.er, e.ef);
      end
    end
  end
  initial begin
    // flags column is {carry, overflow, zero, negative}
    tv.push_back(mk(1, 1, 4'b1010, 4'b0101, 3'b000, 0, 4'b0000, 4'b0000));
    tv.push_back(mk(0, 1, 4'b1010, 4'b0101, 3'b000, 1, 4'b1111, 4'b0001));
    tv.push_back(mk(0, 1, 4'b1010, 4'b0101, 3'b001, 1, 4'b0101, 4'b0100));
    tv.push_back(mk(0, 1, 4'b1010, 4'b0101, 3'b010, 1, 4'b0000, 4'b0010));
    tv.push_back(mk(0, 1, 4'b1010, 4'b0101, 3'b011, 1, 4'b1111, 4'b0001));
    tv.push_back(mk(0, 1, 4'b1010, 4'b0101, 3'b100, 1, 4'b1111, 4'b0001));
    tv.push_back(mk(0, 1, 4'b1010, 4'b0101, 3'b101, 1, 4'b0101, 4'b0000));
    tv.push_back(mk(0, 1, 4'b1010, 4'b0101, 3'b110, 1, 4'b1011, 4'b0001));
    tv.push_back(mk(0, 1, 4'b1010, 4'b0101, 3'b111, 1, 4'b1001, 4'b0001));
    tv.push_back(mk(0, 1, 4'b1111, 4'b0001, 3'b000, 1, 4'b0000, 4'b1010));
    tv.push_back(mk(0, 1, 4'b0111, 4'b0001, 3'b000, 1, 4'b1000, 4'b0101));
    tv.push_back(mk(0, 1, 4'b0011, 4'b0101, 3'b001, 1, 4'b1110, 4'b1001));
    tv.push_back(mk(0, 1, 4'b0000, 4'b0110, 3'b111, 1, 4'b1111, 4'b1001));
    tv.push_back(mk(0, 1, 4'b1000, 4'b0001, 3'b001, 1, 4'b0111, 4'b0100));
    tv.push_back(mk(0, 1, 4'b1100, 4'b1100, 3'b100, 1, 4'b0000, 4'b0010));
    tv.push_back(mk(0, 1, 4'b0000, 4'b0011, 3'b101, 1, 4'b1111, 4'b0001));
    tv.push_back(mk(0, 1, 4'b0001, 4'b0001, 3'b000, 1, 4'b0010, 4'b0000));
    tv.push_back(mk(0, 0, 4'b1111, 4'b0001, 3'b000, 0, 4'b0010, 4'b0000));
    tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 3'b101, 0, 4'b0010, 4'b0000));
    tv.push_back(mk(0, 0, 4'b0111, 4'b1001, 3'b001, 0, 4'b0010, 4'b0000));
    tv.push_back(mk(0, 1, 4'b0111, 4'b0001, 3'b000, 1, 4'b1000, 4'b0101));
    tv.push_back(mk(1, 1, 4'b0011, 4'b0101, 3'b001, 0, 4'b0000, 4'b0000));
    tv.push_back(mk(0, 1, 4'b1100, 4'b0011, 3'b011, 1, 4'b1111, 4'b0001));
    tv.push_back(mk(0, 0, 4'b0000, 4'b0000, 3'b000, 0, 4'b1111, 4'b0001));
    tv.push_back(mk(1, 0, 4'b0000, 4'b0000, 3'b000, 0, 4'b0000, 4'b0000));
    tv.push_back(mk(0, 0, 4'b0101, 4'b0101, 3'b001, 0, 4'b0000, 4'b0000));
    // driver: apply each vector mid-cycle and queue what the next edge must produce
    foreach (tv[i]) begin
      exp_t e;
      @(negedge clk);
      rst = tv[i].r; in_valid = tv[i].v; A = tv[i].a; B = tv[i].b; sel = tv[i].s;
      e.ev = tv[i].ev; e.er = tv[i].er; e.ef = tv[i].ef;
      sb.push_back(e);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected outputs never checked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
